data_memory: RTL

//   Data-side memory stage that sits directly downstream of the core. It consumes
//   the core's memory_address, memory_value and memory_write_sections outputs.
//   The block provides byte-addressable block RAM with registered reads, and a

---
 rtl/data_memory.sv | 117 +++++++++++
 1 files changed

// File: rtl/data_memory.sv
// data_memory
//   Data-side memory stage sitting directly downstream of the core. It provides
//   a byte-addressable RAM with registered reads, a memory-mapped LED register,
//   and a sticky fault flag that keeps the address of the first illegal access.
//
//   Ports
//     clock          single clock for all state
//     reset          synchronous, active-high; clears outputs, keeps RAM
//     address        byte address from the core
//     write_data     store data, byte-lane aligned (lane 0 = bits [7:0])
//     write_sections 3'b001 SB, 3'b011 SH, 3'b111 SW, 3'b000 read
//     read_data      registered read word, one cycle after the read
//     led_on         LED register bit 0
//     fault          sticky illegal-access flag
//     fault_address  address of the first faulting access
module data_memory #(
  parameter int unsigned MEMORY_SIZE = 32'h1000,
  parameter logic [31:0] LED_ADDRESS = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [2:0]  write_sections,
  output logic [31:0] read_data,
  output logic        led_on,
  output logic        fault,
  output logic [31:0] fault_address
);

  localparam int unsigned ADDR_BITS = $clog2(MEMORY_SIZE);
  localparam int unsigned ROW_BITS  = ADDR_BITS - 2;
  localparam int unsigned ROWS      = MEMORY_SIZE / 4;
  localparam logic [31:0] MEM_LIMIT = 32'(MEMORY_SIZE);

  // Four byte-wide banks, one per lane, so each lane can be written alone.
  logic [7:0] mem [4][ROWS];

  logic [ROW_BITS-1:0] row;
  logic [31:0]         ram_word;
  logic                in_ram;
  logic                is_led;
  logic                is_read;
  logic                is_sb;
  logic                is_sh;
  logic                is_sw;
  logic                bad;
  logic                write_ok;
  logic [3:0]          lane_we;
  logic [31:0]         lane_data;

  assign row      = address[ADDR_BITS-1:2];
  assign ram_word = {mem[3][row], mem[2][row], mem[1][row], mem[0][row]};

  // Full 32-bit compare: addresses at or above MEMORY_SIZE never alias into RAM.
  assign in_ram  = (address < MEM_LIMIT);
  assign is_led  = (address[31:2] == LED_ADDRESS[31:2]);
  assign is_read = (write_sections == 3'b000);
  assign is_sb   = (write_sections == 3'b001);
  assign is_sh   = (write_sections == 3'b011);
  assign is_sw   = (write_sections == 3'b111);

  always_comb begin
    bad       = 1'b0;
    write_ok  = 1'b0;
    lane_we   = 4'b0000;
    lane_data = write_data;

    if (!(in_ram || is_led))                         bad = 1'b1;
    if (!is_read && !(is_sb || is_sh || is_sw))      bad = 1'b1;
    if (is_sh && address[0])                         bad = 1'b1;
    if (is_sw && (address[1:0] != 2'b00))            bad = 1'b1;

    write_ok = !is_read && !bad;

    // Replicate the low byte/half across lanes; the enables pick the lane.
    if (is_sb)      lane_data = {4{write_data[7:0]}};
    else if (is_sh) lane_data = {2{write_data[15:0]}};

    if (write_ok && in_ram) begin
      if (is_sb)      lane_we[address[1:0]] = 1'b1;
      else if (is_sh) lane_we = address[1] ? 4'b1100 : 4'b0011;
      else            lane_we = 4'b1111;
    end
  end

  // RAM has no reset so it maps onto block RAM; reset only blocks the write.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_we[i]) mem[i][row] <= lane_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      read_data     <= 32'h0;
      led_on        <= 1'b0;
      fault         <= 1'b0;
      fault_address <= 32'h0;
    end else begin
      // read_data only updates on read cycles and holds through writes.
      if (is_read) begin
        if (in_ram)      read_data <= ram_word;
        else if (is_led) read_data <= {31'b0, led_on};
        else             read_data <= 32'h0;
      end
      if (write_ok && is_led) led_on <= write_data[0];
      if (bad && !fault) begin
        fault         <= 1'b1;
        fault_address <= address;
      end
    end
  end

endmodule
